// File: rtl/coord_pkg.sv
// Shared types and constants for the coordinate entry front end.
package coord_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FULL    = 2'd1,
        OFFER   = 2'd2
    } entry_state_t;

    localparam logic [3:0] COORD_MAX      = 4'd9;
    localparam int         BITS_PER_COORD = 4;
    localparam int         BITS_PER_MOVE  = 8;

    function automatic logic coord_ok(input logic [3:0] y, input logic [3:0] x);
        return (y <= COORD_MAX) && (x <= COORD_MAX);
    endfunction

endpackage

// File: rtl/coord_entry_btn_cond.sv
// Button conditioner: 2-flop synchroniser, optional debounce, rising-edge press pulse.
// Debounce counter is present only when COORD_ENTRY_DEBOUNCE_EN is defined.
module btn_cond #(
    parameter int DEB_CYCLES = 50000,
    parameter int DEB_W      = 16
) (
    input  logic clck,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    logic sync0_r;
    logic sync1_r;
    logic level_s;
    logic prev_r;

    if ((DEB_CYCLES < 1) || ((DEB_CYCLES >> DEB_W) != 0)) begin : g_bad_cfg
        $error("btn_cond: DEB_W too narrow for DEB_CYCLES");
    end

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge clck) begin
        if (rst) begin
            sync0_r <= 1'b0;
            sync1_r <= 1'b0;
        end else begin
            sync0_r <= raw;
            sync1_r <= sync0_r;
        end
    end

`ifdef COORD_ENTRY_DEBOUNCE_EN
    logic [DEB_W-1:0] cnt_r;
    logic             level_r;

    // Accept a new level only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clck) begin
        if (rst) begin
            cnt_r   <= '0;
            level_r <= 1'b0;
        end else if (sync1_r == level_r) begin
            cnt_r <= '0;
        end else if (cnt_r == DEB_W'(DEB_CYCLES - 1)) begin
            cnt_r   <= '0;
            level_r <= sync1_r;
        end else begin
            cnt_r <= cnt_r + {{(DEB_W-1){1'b0}}, 1'b1};
        end
    end

    assign level_s = level_r;
`else
    assign level_s = sync1_r;
`endif

    // One-cycle pulse on each accepted rising level.
    always_ff @(posedge clck) begin
        if (rst) begin
            prev_r <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            prev_r <= level_s;
            pulse  <= level_s & ~prev_r;
        end
    end

endmodule

// File: rtl/coord_entry.sv
// Serial coordinate entry: eight button bits -> Y/X nibbles, range check, valid/ready offer.
// Build option COORD_ENTRY_DEBOUNCE_EN enables the per-button debounce counters.
module coord_entry
    import coord_pkg::*;
#(
    parameter int DEB_CYCLES = 50000,
    parameter int DEB_W      = 16
) (
    input  logic       clck,
    input  logic       rst,
    input  logic       b0,
    input  logic       b1,
    input  logic       activate,
    output logic       move_valid,
    input  logic       move_ready,
    output logic [3:0] move_y,
    output logic [3:0] move_x,
    output logic [3:0] bit_count,
    output logic       entry_err
);

    logic         b0_p_s;
    logic         b1_p_s;
    logic         act_p_s;
    logic         bit_p_s;
    entry_state_t state_r;
    logic [3:0]   y_buf_r;
    logic [3:0]   x_buf_r;

    btn_cond #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_b0  (.clck(clck), .rst(rst), .raw(b0),       .pulse(b0_p_s));
    btn_cond #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_b1  (.clck(clck), .rst(rst), .raw(b1),       .pulse(b1_p_s));
    btn_cond #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_act (.clck(clck), .rst(rst), .raw(activate), .pulse(act_p_s));

    // Simultaneous b0 and b1 presses are ambiguous and enter nothing.
    assign bit_p_s = b0_p_s ^ b1_p_s;

    // Entry FSM, shift buffers and handshake register.
    always_ff @(posedge clck) begin
        if (rst) begin
            state_r    <= COLLECT;
            y_buf_r    <= 4'd0;
            x_buf_r    <= 4'd0;
            bit_count  <= 4'd0;
            move_valid <= 1'b0;
            move_y     <= 4'd0;
            move_x     <= 4'd0;
            entry_err  <= 1'b0;
        end else begin
            entry_err <= 1'b0;
            case (state_r)
                COLLECT: begin
                    if (act_p_s) begin
                        entry_err <= 1'b1;
                        y_buf_r   <= 4'd0;
                        x_buf_r   <= 4'd0;
                        bit_count <= 4'd0;
                    end else if (bit_p_s) begin
                        // First bit of each nibble ends up as its LSB.
                        if (bit_count < 4'(BITS_PER_COORD)) begin
                            y_buf_r <= {b1_p_s, y_buf_r[3:1]};
                        end else begin
                            x_buf_r <= {b1_p_s, x_buf_r[3:1]};
                        end
                        bit_count <= bit_count + 4'd1;
                        if (bit_count == 4'(BITS_PER_MOVE - 1)) begin
                            state_r <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (act_p_s) begin
                        if (coord_ok(y_buf_r, x_buf_r)) begin
                            move_y     <= y_buf_r;
                            move_x     <= x_buf_r;
                            move_valid <= 1'b1;
                            state_r    <= OFFER;
                        end else begin
                            entry_err <= 1'b1;
                            y_buf_r   <= 4'd0;
                            x_buf_r   <= 4'd0;
                            bit_count <= 4'd0;
                            state_r   <= COLLECT;
                        end
                    end
                end
                OFFER: begin
                    if (move_ready) begin
                        move_valid <= 1'b0;
                        y_buf_r    <= 4'd0;
                        x_buf_r    <= 4'd0;
                        bit_count  <= 4'd0;
                        state_r    <= COLLECT;
                    end
                end
                default: begin
                    move_valid <= 1'b0;
                    y_buf_r    <= 4'd0;
                    x_buf_r    <= 4'd0;
                    bit_count  <= 4'd0;
                    state_r    <= COLLECT;
                end
            endcase
        end
    end

endmodule
